// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB3 32-bit down-counting timer with 16-bit prescaler, periodic reload and level IRQ.
// Define APB_TIMER_PSTRB_EN to add the PSTRB port and byte-masked register writes.
module apb_timer_slave #(
    parameter logic [31:0] ID_VALUE = 32'h5449_4D52,
    parameter int          ADDR_W   = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
`ifdef APB_TIMER_PSTRB_EN
    input  logic [3:0]        PSTRB,
`endif
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              IRQ
);
    typedef enum logic [1:0] {IDLE, RWAIT, DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [31:0]       load_q, load_d, value_q, value_d, prdata_q, prdata_d;
    logic [15:0]       prescale_q, prescale_d, pcnt_q, pcnt_d;
    logic              intstat_q, intstat_d, irq_q, irq_d, pslverr_q, pslverr_d;
    logic [3:0]        strb;
    logic [31:0]       wmask, load_wr, rdata;
    logic [15:0]       prescale_wr;
    logic [ADDR_W-3:0] idx;
    logic              acc, bad_addr, wr_err, wr_ok, wr_ctrl, wr_load, wr_pre, w1c, tick, expire;
    logic              unused_addr;

`ifdef APB_TIMER_PSTRB_EN
    assign strb = PSTRB;
`else
    assign strb = 4'hF;
`endif

    assign unused_addr = ^PADDR[1:0];
    assign idx         = PADDR[ADDR_W-1:2];
    assign wmask       = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    assign load_wr     = (load_q & ~wmask) | (PWDATA & wmask);
    assign prescale_wr = (prescale_q & ~wmask[15:0]) | (PWDATA[15:0] & wmask[15:0]);

    assign acc      = PSEL && PENABLE && state_q == IDLE;
    assign bad_addr = idx > 5;
    assign wr_err   = bad_addr || idx == 2 || idx == 5;
    assign wr_ok    = acc && PWRITE && !wr_err;
    assign wr_ctrl  = wr_ok && idx == 0 && strb[0];
    assign wr_load  = wr_ok && idx == 1 && |strb;
    assign wr_pre   = wr_ok && idx == 3;
    assign w1c      = wr_ok && idx == 4 && strb[0] && PWDATA[0];

    // A CTRL write that clears EN swallows a coincident tick.
    assign tick   = ctrl_q[0] && pcnt_q == prescale_q && !(wr_ctrl && !PWDATA[0]);
    assign expire = tick && value_q == '0;

    assign rdata = idx == 0 ? {29'd0, ctrl_q} :
                   idx == 1 ? load_q :
                   idx == 2 ? value_q :
                   idx == 3 ? {16'd0, prescale_q} :
                   idx == 4 ? {31'd0, intstat_q} : ID_VALUE;

    // Writes complete with zero wait states; reads use the RWAIT/DONE sequence.
    assign PREADY  = state_q == RWAIT || (acc && PWRITE);
    assign PSLVERR = state_q == RWAIT ? pslverr_q : acc && PWRITE && wr_err;
    assign PRDATA  = state_q == RWAIT ? prdata_q : '0;
    assign IRQ     = irq_q;

    always_comb begin
        ctrl_d     = wr_ctrl ? PWDATA[2:0] : {ctrl_q[2:1], ctrl_q[0] && !(expire && !ctrl_q[1])};
        load_d     = wr_load ? load_wr : load_q;
        value_d    = wr_load ? load_wr : !tick ? value_q : !expire ? value_q - 32'd1 : ctrl_q[1] ? load_q : '0;
        prescale_d = wr_pre ? prescale_wr : prescale_q;
        pcnt_d     = (wr_load || (wr_ctrl && PWDATA[0] && !ctrl_q[0])) ? '0 :
                     !ctrl_q[0] ? pcnt_q : pcnt_q == prescale_q ? '0 : pcnt_q + 16'd1;
        intstat_d  = expire || (intstat_q && !w1c);
        irq_d      = intstat_q && ctrl_q[2];
        state_d    = state_q == IDLE ? (acc && !PWRITE ? RWAIT : IDLE) : state_q == RWAIT ? DONE : IDLE;
        prdata_d   = acc && !PWRITE ? (bad_addr ? '0 : rdata) : prdata_q;
        pslverr_d  = acc && !PWRITE ? bad_addr : pslverr_q;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            load_q     <= '0;
            value_q    <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            intstat_q  <= 1'b0;
            irq_q      <= 1'b0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            value_q    <= value_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            intstat_q  <= intstat_d;
            irq_q      <= irq_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
        end
    end
endmodule
